// File: rtl/avalon_mem_arbiter_if.sv
// rtl/avalon_mem_arbiter_if.sv - Avalon-MM bundle for the two-master / one-slave arbiter
interface avalon_mem_arbiter_if;
   logic [31:0] m0_address;
   logic [3:0]  m0_byteenable;
   logic        m0_read;
   logic        m0_write;
   logic [31:0] m0_writedata;
   logic        m0_waitrequest;
   logic [31:0] m0_readdata;

   logic [31:0] m1_address;
   logic [3:0]  m1_byteenable;
   logic        m1_read;
   logic        m1_write;
   logic [31:0] m1_writedata;
   logic        m1_waitrequest;
   logic [31:0] m1_readdata;

   logic [31:0] s_address;
   logic [3:0]  s_byteenable;
   logic        s_read;
   logic        s_write;
   logic [31:0] s_writedata;
   logic        s_waitrequest;
   logic [31:0] s_readdata;

   // slave: the arbiter's view (it serves both masters and drives the memory port)
   modport slave (
      input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      output m0_waitrequest, m0_readdata,
      input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
      output m1_waitrequest, m1_readdata,
      output s_address, s_byteenable, s_read, s_write, s_writedata,
      input  s_waitrequest, s_readdata
   );

   // master: the surrounding masters and memory that connect to the arbiter
   modport master (
      output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      input  m0_waitrequest, m0_readdata,
      output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
      input  m1_waitrequest, m1_readdata,
      input  s_address, s_byteenable, s_read, s_write, s_writedata,
      output s_waitrequest, s_readdata
   );
endinterface

// File: rtl/avalon_mem_arbiter.sv
// rtl/avalon_mem_arbiter.sv - two-master Avalon-MM arbiter with registered grant and stall watchdog
module avalon_mem_arbiter #(
   parameter int ROUND_ROBIN    = 1,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                        clk,
   input  logic                        reset_n,
   avalon_mem_arbiter_if.slave         bus,
   output logic [1:0]                  grant,
   output logic                        timeout
);
   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state, state_next;
   logic        owner, owner_next;
   logic        last, last_next;
   logic [15:0] stall_cnt, stall_next, stall_inc;
   logic        timeout_next;
   logic        req0, req1, winner;
   logic        own_read, own_write;

   assign req0      = bus.m0_read | bus.m0_write;
   assign req1      = bus.m1_read | bus.m1_write;
   assign own_read  = owner ? bus.m1_read  : bus.m0_read;
   assign own_write = owner ? bus.m1_write : bus.m0_write;

   // Address/data always follow the owner; only the strobes are gated by state.
   assign bus.s_address    = owner ? bus.m1_address    : bus.m0_address;
   assign bus.s_byteenable = owner ? bus.m1_byteenable : bus.m0_byteenable;
   assign bus.s_writedata  = owner ? bus.m1_writedata  : bus.m0_writedata;
   assign bus.m0_readdata  = bus.s_readdata;
   assign bus.m1_readdata  = bus.s_readdata;

   always_comb begin
      if (req0 && req1)
         winner = (ROUND_ROBIN != 0) ? ~last : 1'b0;
      else
         winner = req1;
   end

   always_comb begin
      state_next         = state;
      owner_next         = owner;
      last_next          = last;
      stall_inc          = 16'd0;
      stall_next         = stall_cnt;
      timeout_next       = timeout;
      grant              = 2'b00;
      bus.s_read         = 1'b0;
      bus.s_write        = 1'b0;
      bus.m0_waitrequest = 1'b1;
      bus.m1_waitrequest = 1'b1;

      case (state)
         IDLE: begin
            stall_next = 16'd0;
            if (req0 || req1) begin
               state_next = BUSY;
               owner_next = winner;
            end
         end
         BUSY: begin
            bus.s_read  = own_read;
            bus.s_write = own_write & ~own_read;
            grant       = owner ? 2'b10 : 2'b01;
            if (owner)
               bus.m1_waitrequest = bus.s_waitrequest;
            else
               bus.m0_waitrequest = bus.s_waitrequest;

            if (bus.s_waitrequest)
               stall_inc = (stall_cnt == 16'hFFFF) ? stall_cnt : stall_cnt + 16'd1;
            if (stall_inc >= TIMEOUT_LIMIT)
               timeout_next = 1'b1;
            stall_next = stall_inc;

            if (!(own_read || own_write)) begin
               // Abandoned request: release the port without crediting the owner.
               state_next = IDLE;
               stall_next = 16'd0;
            end else if (!bus.s_waitrequest) begin
               state_next = IDLE;
               last_next  = owner;
               stall_next = 16'd0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         owner     <= 1'b0;
         last      <= 1'b1;
         stall_cnt <= 16'd0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_next;
         owner     <= owner_next;
         last      <= last_next;
         stall_cnt <= stall_next;
         timeout   <= timeout_next;
      end
   end
endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// tb/tb_avalon_mem_arbiter.sv - directed vector bench for avalon_mem_arbiter
module tb_avalon_mem_arbiter;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic r0 = 1'b0, w0 = 1'b0, r1 = 1'b0, w1 = 1'b0, sw = 1'b0;
   logic [1:0] grant_a, grant_b;
   logic       timeout_a, timeout_b;

   avalon_mem_arbiter_if ifa();
   avalon_mem_arbiter_if ifb();

   assign ifa.m0_address = 32'h0000_0100;   assign ifb.m0_address = 32'h0000_0100;
   assign ifa.m0_byteenable = 4'hF;         assign ifb.m0_byteenable = 4'hF;
   assign ifa.m0_writedata = 32'hAAAA_5555; assign ifb.m0_writedata = 32'hAAAA_5555;
   assign ifa.m0_read = r0;                 assign ifb.m0_read = r0;
   assign ifa.m0_write = w0;                assign ifb.m0_write = w0;
   assign ifa.m1_address = 32'h0000_0200;   assign ifb.m1_address = 32'h0000_0200;
   assign ifa.m1_byteenable = 4'b0011;      assign ifb.m1_byteenable = 4'b0011;
   assign ifa.m1_writedata = 32'h1234_5678; assign ifb.m1_writedata = 32'h1234_5678;
   assign ifa.m1_read = r1;                 assign ifb.m1_read = r1;
   assign ifa.m1_write = w1;                assign ifb.m1_write = w1;
   assign ifa.s_waitrequest = sw;           assign ifb.s_waitrequest = sw;
   assign ifa.s_readdata = 32'hDEAD_BEEF;   assign ifb.s_readdata = 32'hDEAD_BEEF;

   avalon_mem_arbiter #(.ROUND_ROBIN(1), .TIMEOUT_CYCLES(4)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(ifa), .grant(grant_a), .timeout(timeout_a));
   avalon_mem_arbiter #(.ROUND_ROBIN(0), .TIMEOUT_CYCLES(4)) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(ifb), .grant(grant_b), .timeout(timeout_b));

   typedef struct packed {
      logic r0, w0, r1, w1, sw;
      logic [1:0] grant;
      logic sr, swr, wq0, wq1;
   } vec_t;

   vec_t tv[$];
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   initial begin
      vec_t idle0, both_i, both_g0, both_g1, wr_stall;
      idle0    = '{0,0,0,0,0, 2'b00, 0,0,1,1};
      both_i   = '{1,0,1,0,0, 2'b00, 0,0,1,1};
      both_g0  = '{1,0,1,0,0, 2'b01, 1,0,0,1};
      both_g1  = '{1,0,1,0,0, 2'b10, 1,0,1,0};
      wr_stall = '{0,0,0,1,1, 2'b10, 0,1,1,1};
      // round-robin contention, master 0 first after reset
      for (int k = 0; k < 2; k++) begin
         tv.push_back(both_i); tv.push_back(both_g0);
         tv.push_back(both_i); tv.push_back(both_g1);
      end
      tv.push_back('{1,0,0,0,0, 2'b00, 0,0,1,1});
      tv.push_back('{1,0,0,0,0, 2'b01, 1,0,0,1});
      tv.push_back(idle0);
      // master 1 write, three stall cycles
      tv.push_back('{0,0,0,1,1, 2'b00, 0,0,1,1});
      tv.push_back(wr_stall); tv.push_back(wr_stall); tv.push_back(wr_stall);
      tv.push_back('{0,0,0,1,0, 2'b10, 0,1,1,0});
      tv.push_back(idle0);
      // read+write together is a read
      tv.push_back('{1,1,0,0,0, 2'b00, 0,0,1,1});
      tv.push_back('{1,1,0,0,0, 2'b01, 1,0,0,1});
      tv.push_back(idle0);
      // abandoned request leaves last untouched, so the next tie goes to master 1
      tv.push_back('{0,0,1,0,1, 2'b00, 0,0,1,1});
      tv.push_back('{0,0,1,0,1, 2'b10, 1,0,1,1});
      tv.push_back('{0,0,0,0,1, 2'b10, 0,0,1,1});
      tv.push_back(both_i);
      tv.push_back(both_g1);
      tv.push_back(idle0);

      repeat (2) @(negedge clk);
      #1;
      chk("rst_grant", grant_a, 2'b00);
      chk("rst_s_read", ifa.s_read, 1'b0);
      chk("rst_s_write", ifa.s_write, 1'b0);
      chk("rst_m0_wait", ifa.m0_waitrequest, 1'b1);
      chk("rst_m1_wait", ifa.m1_waitrequest, 1'b1);
      chk("rst_timeout", timeout_a, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;

      foreach (tv[i]) begin
         @(negedge clk);
         {r0, w0, r1, w1, sw} = {tv[i].r0, tv[i].w0, tv[i].r1, tv[i].w1, tv[i].sw};
         #1;
         chk($sformatf("v%0d grant", i), grant_a, tv[i].grant);
         chk($sformatf("v%0d s_read", i), ifa.s_read, tv[i].sr);
         chk($sformatf("v%0d s_write", i), ifa.s_write, tv[i].swr);
         chk($sformatf("v%0d m0_wait", i), ifa.m0_waitrequest, tv[i].wq0);
         chk($sformatf("v%0d m1_wait", i), ifa.m1_waitrequest, tv[i].wq1);
         if (tv[i].grant == 2'b01) begin
            chk($sformatf("v%0d s_addr", i), ifa.s_address, 32'h100);
            chk($sformatf("v%0d s_be", i), ifa.s_byteenable, 4'hF);
            chk($sformatf("v%0d s_wdata", i), ifa.s_writedata, 32'hAAAA_5555);
            chk($sformatf("v%0d m0_rdata", i), ifa.m0_readdata, 32'hDEAD_BEEF);
         end else if (tv[i].grant == 2'b10) begin
            chk($sformatf("v%0d s_addr", i), ifa.s_address, 32'h200);
            chk($sformatf("v%0d s_be", i), ifa.s_byteenable, 4'b0011);
            chk($sformatf("v%0d s_wdata", i), ifa.s_writedata, 32'h1234_5678);
         end
         chk($sformatf("v%0d timeout", i), timeout_a, 1'b0);
      end

      // fixed priority: master 0 keeps winning until it lets go
      @(negedge clk);
      r0 = 1'b1; r1 = 1'b1; sw = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1 chk($sformatf("fp%0d idle", k), grant_b, 2'b00);
         @(negedge clk);
         #1 chk($sformatf("fp%0d grant", k), grant_b, 2'b01);
         @(negedge clk);
      end
      r0 = 1'b0;
      #1 chk("fp_idle_last", grant_b, 2'b00);
      @(negedge clk);
      #1 chk("fp_grant_m1", grant_b, 2'b10);
      chk("fp_m1_wait", ifb.m1_waitrequest, 1'b0);
      @(negedge clk);
      r1 = 1'b0;
      @(negedge clk);

      // watchdog: ten stalled cycles, limit of four
      r0 = 1'b1; sw = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         #1 chk($sformatf("to_stall%0d", i), timeout_a, (i - 1) >= 4);
         chk($sformatf("to_wait%0d", i), ifa.m0_waitrequest, 1'b1);
      end
      @(negedge clk);
      sw = 1'b0;
      #1 chk("to_release_wait", ifa.m0_waitrequest, 1'b0);
      chk("to_release_grant", grant_a, 2'b01);
      chk("to_sticky1", timeout_a, 1'b1);
      @(negedge clk);
      r0 = 1'b0;
      #1 chk("to_done_grant", grant_a, 2'b00);
      chk("to_sticky2", timeout_a, 1'b1);

      // reset in the middle of a stalled transfer
      @(negedge clk);
      r1 = 1'b1; sw = 1'b1;
      @(negedge clk);
      #1 chk("mr_busy_grant", grant_a, 2'b10);
      chk("mr_busy_read", ifa.s_read, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("mr_s_read", ifa.s_read, 1'b0);
      chk("mr_s_write", ifa.s_write, 1'b0);
      chk("mr_grant", grant_a, 2'b00);
      chk("mr_m0_wait", ifa.m0_waitrequest, 1'b1);
      chk("mr_m1_wait", ifa.m1_waitrequest, 1'b1);
      chk("mr_timeout", timeout_a, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      r0 = 1'b1; r1 = 1'b1; sw = 1'b0;
      @(negedge clk);
      #1 chk("mr_tie_m0", grant_a, 2'b01);
      @(negedge clk);
      r0 = 1'b0; r1 = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
